dp_ram_be: RTL and testbench
============================

# dp_ram_be

Parametrised true dual-port synchronous RAM for the softcore CPU. It replaces the fixed 256x8 byte memory with configurable address and data width, per-byte write enables, and independent per-port enables. It also adds a configurable read pipeline depth, a selectable same-port read-during-write mode, and detection of write-write collisions. It serves as shared instruction/data memory: port 1 is the fetch/load-store port and port 2 is the debug/DMA port.

## Interface
- ADDR_W, 8, address width; depth = 2**ADDR_W words
- DATA_W, 8, word width; must be a multiple of 8
- RD_LATENCY, 1, read latency in cycles; legal values 1 or 2
- WRITE_MODE, 0, same-port write response: 0 = read-first (old data), 1 = write-first (new merged data)
- clk  input  1  clock; all activity on rising edge
- rst  input  1  reset, asynchronous, active-high
- en_port_1  input  1  port 1 access request this cycle
- addr_in_port_1  input  ADDR_W  port 1 word address
- data_in_port_1  input  DATA_W  port 1 write data
- r_w_port_1  input  1  0 = read, 1 = write
- be_port_1  input  DATA_W/8  byte enables for writes; bit i covers data[8i+7:8i]
- data_out_port_1  output  DATA_W  port 1 read data
- rvalid_port_1  output  1  data_out_port_1 carries the response to an access
- en_port_2, addr_in_port_2, data_in_port_2, r_w_port_2, be_port_2, data_out_port_2, rvalid_port_2: same as port 1, for port 2
- collision  output  1  registered pulse: both ports wrote the same address in the previous cycle

## Operation
- Memory array: 2**ADDR_W x DATA_W. Contents are not affected by rst and are undefined at power-up.
- An access happens when en_port_N=1 at a rising edge. With en_port_N=0, the port neither reads nor writes, and its be/data/addr inputs are ignored.
- Write (r_w=1): only the byte lanes with be bit = 1 are updated. be=0 with r_w=1 is a legal no-op write that still produces a response.
- Every access (read or write) produces exactly one response: rvalid_port_N=1 for one cycle, RD_LATENCY cycles later.
- Read response: the word at addr as it was before any same-cycle write.
- Write response with WRITE_MODE=0: the old word. With WRITE_MODE=1: the merged word (new bytes where be=1, old bytes elsewhere).
- Cross-port same cycle, same address, one port reads and the other writes: the reader always gets the old word, whatever WRITE_MODE is.
- Both ports write the same address in the same cycle:
  - Byte lanes enabled on port 1 take port 1 data.
  - Lanes enabled only on port 2 take port 2 data.
  - collision=1 in the next cycle. collision pulses even if the be masks do not overlap.
- data_out_port_N holds its last value while rvalid_port_N=0. It changes only when a new response is presented.
- Ports are fully independent otherwise. There is no backpressure and a new access is accepted every cycle.

## Timing
- Reset values: data_out_port_1 = data_out_port_2 = 0, rvalid_port_1 = rvalid_port_2 = 0, collision = 0. Any internal pipeline valid bits are cleared as well.
- rst asserted mid-operation: in-flight responses are dropped, with no rvalid after release. Writes already clocked in before rst remain in memory.
- While rst=1, accesses are ignored and memory is not written.
- The first access is accepted on the first rising edge with rst=0.
- RD_LATENCY=1: access at edge T gives rvalid/data_out high from edge T to edge T+1.
- RD_LATENCY=2: access at edge T gives rvalid/data_out valid between edges T+1 and T+2. There is one pipeline register stage per port, and throughput is one access per cycle per port.
- Back-to-back write then read to the same address on one port (cycles T, T+1): the read returns the written data, with no hazard.
- collision: asserted between edges T and T+1 for colliding writes at edge T. It is independent of RD_LATENCY.
- Address wrap: addresses are exactly ADDR_W bits, so there is no out-of-range case.

## Test plan
- Reset: assert rst mid-burst with RD_LATENCY=2 and two reads in flight.
  - Outputs go to 0 immediately, without a clock edge.
  - No rvalid appears after release.
- Byte-enable merge: DATA_W=32, write 0xAABBCCDD to addr 5 with be=4'b1111, then write 0x11223344 with be=4'b0101, then read addr 5.
  - Read returns 0xAA22CC44 with rvalid exactly RD_LATENCY cycles after the read.
- WRITE_MODE: with addr 3 holding 0x10, write 0x20 on port 1 with be all-ones.
  - WRITE_MODE=0: response data is 0x10.
  - WRITE_MODE=1: response data is 0x20.
  - A subsequent read returns 0x20 in both modes.
- Cross-port read-during-write: with addr 7 holding 0x55, in the same cycle port 1 writes 0x66 and port 2 reads addr 7.
  - Port 2 returns 0x55.
  - A port 2 read in the next cycle returns 0x66.
- Write-write collision: DATA_W=16, addr 9; port 1 writes 0x1234 with be=2'b01 while port 2 writes 0xABCD with be=2'b11.
  - Memory holds 0xAB34.
  - collision=1 for exactly one cycle.
  - Repeating the same writes to different addresses gives collision=0.
- Throughput and hold: 16 consecutive reads on both ports with incrementing addresses, then 4 idle cycles.
  - 16 contiguous rvalid pulses per port, with correct data in order.
  - data_out holds the final word during the idle cycles.

Source files
------------

// File: rtl/dp_ram_be.sv
// dp_ram_be: true dual-port synchronous RAM with per-byte write enables,
// a read pipeline of 1 or 2 cycles, a selectable same-port read-during-write
// response, and detection of write-write collisions.
module dp_ram_be #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned WRITE_MODE = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en_port_1,
    input  logic [ADDR_W-1:0]   addr_in_port_1,
    input  logic [DATA_W-1:0]   data_in_port_1,
    input  logic                r_w_port_1,
    input  logic [DATA_W/8-1:0] be_port_1,
    output logic [DATA_W-1:0]   data_out_port_1,
    output logic                rvalid_port_1,
    input  logic                en_port_2,
    input  logic [ADDR_W-1:0]   addr_in_port_2,
    input  logic [DATA_W-1:0]   data_in_port_2,
    input  logic                r_w_port_2,
    input  logic [DATA_W/8-1:0] be_port_2,
    output logic [DATA_W-1:0]   data_out_port_2,
    output logic                rvalid_port_2,
    output logic                collision
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned NB    = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    // Per-port request bundles, index 0 = port 1, index 1 = port 2
    logic              acc_c  [2];
    logic              wr_c   [2];
    logic [ADDR_W-1:0] addr_c [2];
    logic [DATA_W-1:0] data_c [2];
    logic [NB-1:0]     be_c   [2];

    assign acc_c[0]  = en_port_1;
    assign acc_c[1]  = en_port_2;
    assign wr_c[0]   = r_w_port_1;
    assign wr_c[1]   = r_w_port_2;
    assign addr_c[0] = addr_in_port_1;
    assign addr_c[1] = addr_in_port_2;
    assign data_c[0] = data_in_port_1;
    assign data_c[1] = data_in_port_2;
    assign be_c[0]   = be_port_1;
    assign be_c[1]   = be_port_2;

    // Array update: port 2 lanes first so port 1 wins any lane both ports enable
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (acc_c[1] && wr_c[1] && be_c[1][b])
                    mem[addr_c[1]][8*b +: 8] <= data_c[1][8*b +: 8];
                if (acc_c[0] && wr_c[0] && be_c[0][b])
                    mem[addr_c[0]][8*b +: 8] <= data_c[0][8*b +: 8];
            end
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [DATA_W-1:0] old_c;
        logic [DATA_W-1:0] merged_c;
        logic [DATA_W-1:0] resp_c;
        logic              in_v_c;
        logic [DATA_W-1:0] in_d_c;
        logic              v_q;
        logic [DATA_W-1:0] d_q;

        // Response word: pre-write contents, or own merged write in write-first mode
        always_comb begin
            old_c    = mem[addr_c[p]];
            merged_c = old_c;
            for (int unsigned b = 0; b < NB; b++) begin
                if (be_c[p][b])
                    merged_c[8*b +: 8] = data_c[p][8*b +: 8];
            end
            resp_c = (wr_c[p] && (WRITE_MODE == 1)) ? merged_c : old_c;
        end

        if (RD_LATENCY == 2) begin : g_pipe
            logic              s_v;
            logic [DATA_W-1:0] s_d;

            // Extra pipeline stage for two-cycle read latency
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s_v <= 1'b0;
                    s_d <= '0;
                end else begin
                    s_v <= acc_c[p];
                    if (acc_c[p])
                        s_d <= resp_c;
                end
            end

            assign in_v_c = s_v;
            assign in_d_c = s_d;
        end else begin : g_direct
            assign in_v_c = acc_c[p];
            assign in_d_c = resp_c;
        end

        // Output register: data only moves when a new response is presented
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
                d_q <= '0;
            end else begin
                v_q <= in_v_c;
                if (in_v_c)
                    d_q <= in_d_c;
            end
        end
    end

    assign rvalid_port_1   = g_port[0].v_q;
    assign data_out_port_1 = g_port[0].d_q;
    assign rvalid_port_2   = g_port[1].v_q;
    assign data_out_port_2 = g_port[1].d_q;

    // Flag both ports writing one address, regardless of byte-enable overlap
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            collision <= 1'b0;
        else
            collision <= en_port_1 && en_port_2 && r_w_port_1 && r_w_port_2 &&
                         (addr_in_port_1 == addr_in_port_2);
    end

endmodule

// File: tb/tb_dp_ram_be.sv
// Testbench for dp_ram_be: two instances (latency 1 / read-first and
// latency 2 / write-first) share stimulus; a byte-tracking memory model
// feeds per-port expectation queues that a negedge monitor drains.
module tb_dp_ram_be;

    typedef struct {
        int          due;
        logic [31:0] d;
        bit          ok;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en1 = 1'b0, w1 = 1'b0, en2 = 1'b0, w2 = 1'b0;
    logic [7:0]  a1 = '0, a2 = '0;
    logic [31:0] d1 = '0, d2 = '0;
    logic [3:0]  b1 = '0, b2 = '0;

    logic [31:0] dout [4];
    logic        rv   [4];
    logic        col  [2];

    int          cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    int          lat [2] = '{1, 2};

    exp_t        sb [4][$];
    int          colq [$];
    logic [31:0] last_d [4];
    bit          last_k [4];

    logic [31:0] mdl [256];
    logic [3:0]  kn  [256];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dp_ram_be #(.ADDR_W(8), .DATA_W(32), .RD_LATENCY(1), .WRITE_MODE(0)) u_rf (
        .clk(clk), .rst(rst),
        .en_port_1(en1), .addr_in_port_1(a1), .data_in_port_1(d1), .r_w_port_1(w1), .be_port_1(b1),
        .data_out_port_1(dout[0]), .rvalid_port_1(rv[0]),
        .en_port_2(en2), .addr_in_port_2(a2), .data_in_port_2(d2), .r_w_port_2(w2), .be_port_2(b2),
        .data_out_port_2(dout[1]), .rvalid_port_2(rv[1]),
        .collision(col[0])
    );

    dp_ram_be #(.ADDR_W(8), .DATA_W(32), .RD_LATENCY(2), .WRITE_MODE(1)) u_wf (
        .clk(clk), .rst(rst),
        .en_port_1(en1), .addr_in_port_1(a1), .data_in_port_1(d1), .r_w_port_1(w1), .be_port_1(b1),
        .data_out_port_1(dout[2]), .rvalid_port_1(rv[2]),
        .en_port_2(en2), .addr_in_port_2(a2), .data_in_port_2(d2), .r_w_port_2(w2), .be_port_2(b2),
        .data_out_port_2(dout[3]), .rvalid_port_2(rv[3]),
        .collision(col[1])
    );

    // Monitor: check rvalid timing, response data / hold, and collision each cycle
    always @(negedge clk) begin
        logic exp_v;
        logic exp_c;
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            exp_v = (sb[k].size() > 0) && (sb[k][0].due == cyc);
            n_assert++;
            assert (rv[k] === exp_v) else begin
                n_fail++;
                $error("FAIL rvalid[%0d] cyc=%0d observed=%b expected=%b", k, cyc, rv[k], exp_v);
            end
            if (exp_v) begin
                e = sb[k].pop_front();
                last_d[k] = e.d;
                last_k[k] = e.ok;
            end
            if (last_k[k]) begin
                n_assert++;
                assert (dout[k] === last_d[k]) else begin
                    n_fail++;
                    $error("FAIL data_out[%0d] cyc=%0d observed=%h expected=%h", k, cyc, dout[k], last_d[k]);
                end
            end
        end
        exp_c = (colq.size() > 0) && (colq[0] == cyc);
        for (int k = 0; k < 2; k++) begin
            n_assert++;
            assert (col[k] === exp_c) else begin
                n_fail++;
                $error("FAIL collision[%0d] cyc=%0d observed=%b expected=%b", k, cyc, col[k], exp_c);
            end
        end
        if (exp_c) void'(colq.pop_front());
    end

    // Queue one port's response for both instances, before the model is updated
    task automatic model_resp(input int p, input logic e, input logic w, input logic [7:0] a,
                              input logic [31:0] d, input logic [3:0] b);
        exp_t        x;
        logic [31:0] r;
        logic [3:0]  rk;
        if (e) begin
            for (int k = 0; k < 2; k++) begin
                r  = mdl[a];
                rk = kn[a];
                if (w && k == 1) begin
                    for (int i = 0; i < 4; i++) begin
                        if (b[i]) begin
                            r[8*i +: 8] = d[8*i +: 8];
                            rk[i] = 1'b1;
                        end
                    end
                end
                x.due = cyc + lat[k];
                x.d   = r;
                x.ok  = &rk;
                sb[k*2 + p].push_back(x);
            end
        end
    endtask

    task automatic model_write(input logic e, input logic w, input logic [7:0] a,
                               input logic [31:0] d, input logic [3:0] b);
        if (e && w) begin
            for (int i = 0; i < 4; i++) begin
                if (b[i]) begin
                    mdl[a][8*i +: 8] = d[8*i +: 8];
                    kn[a][i] = 1'b1;
                end
            end
        end
    endtask

    // One clock of stimulus; called just after a rising edge
    task automatic drive(input logic e_1, input logic w_1, input logic [7:0] a_1,
                         input logic [31:0] d_1, input logic [3:0] b_1,
                         input logic e_2, input logic w_2, input logic [7:0] a_2,
                         input logic [31:0] d_2, input logic [3:0] b_2);
        en1 = e_1; w1 = w_1; a1 = a_1; d1 = d_1; b1 = b_1;
        en2 = e_2; w2 = w_2; a2 = a_2; d2 = d_2; b2 = b_2;
        if (!rst) begin
            model_resp(0, e_1, w_1, a_1, d_1, b_1);
            model_resp(1, e_2, w_2, a_2, d_2, b_2);
            if (e_1 && e_2 && w_1 && w_2 && a_1 == a_2)
                colq.push_back(cyc + 1);
            model_write(e_2, w_2, a_2, d_2, b_2);
            model_write(e_1, w_1, a_1, d_1, b_1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    endtask

    task automatic check_zero(input string tag);
        for (int k = 0; k < 4; k++) begin
            n_assert++;
            assert (rv[k] === 1'b0 && dout[k] === 32'h0) else begin
                n_fail++;
                $error("FAIL %s port[%0d] observed rv=%b d=%h expected rv=0 d=0", tag, k, rv[k], dout[k]);
            end
        end
        for (int k = 0; k < 2; k++) begin
            n_assert++;
            assert (col[k] === 1'b0) else begin
                n_fail++;
                $error("FAIL %s collision[%0d] observed=%b expected=0", tag, k, col[k]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mdl[i] = '0;
            kn[i]  = '0;
        end
        for (int k = 0; k < 4; k++) begin
            last_d[k] = '0;
            last_k[k] = 1'b1;
        end

        #2 rst = 1'b1;
        #1 check_zero("reset_init");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Byte-enable merge on addr 5
        drive(1, 1, 8'd5, 32'hAABBCCDD, 4'b1111, 0, 0, 8'd0, 32'h0, 4'h0);
        drive(1, 1, 8'd5, 32'h11223344, 4'b0101, 0, 0, 8'd0, 32'h0, 4'h0);
        drive(1, 0, 8'd5, 32'h0, 4'h0, 0, 0, 8'd0, 32'h0, 4'h0);
        idle(2);

        // Same-port write response: old vs merged word
        drive(1, 1, 8'd3, 32'h10, 4'b1111, 0, 0, 8'd0, 32'h0, 4'h0);
        drive(1, 1, 8'd3, 32'h20, 4'b1111, 0, 0, 8'd0, 32'h0, 4'h0);
        drive(1, 0, 8'd3, 32'h0, 4'h0, 0, 0, 8'd0, 32'h0, 4'h0);
        drive(1, 1, 8'd3, 32'h0, 4'b0000, 0, 0, 8'd0, 32'h0, 4'h0);
        idle(2);

        // Cross-port read during write
        drive(1, 1, 8'd7, 32'h55, 4'b1111, 0, 0, 8'd0, 32'h0, 4'h0);
        drive(1, 1, 8'd7, 32'h66, 4'b1111, 1, 0, 8'd7, 32'h0, 4'h0);
        drive(0, 0, 8'd0, 32'h0, 4'h0, 1, 0, 8'd7, 32'h0, 4'h0);
        idle(2);

        // Write-write collision and its negative cases
        drive(1, 1, 8'd9, 32'h0, 4'b1111, 1, 1, 8'd10, 32'h0, 4'b1111);
        drive(1, 1, 8'd9, 32'h00001234, 4'b0001, 1, 1, 8'd9, 32'h0000ABCD, 4'b0011);
        drive(0, 0, 8'd0, 32'h0, 4'h0, 1, 0, 8'd9, 32'h0, 4'h0);
        drive(1, 1, 8'd10, 32'h00001234, 4'b0001, 1, 1, 8'd11, 32'h0000ABCD, 4'b0011);
        drive(1, 1, 8'd12, 32'h00001234, 4'b0001, 1, 1, 8'd12, 32'h0000ABCD, 4'b0010);
        idle(3);

        // Throughput: fill, then 16 back-to-back reads per port, then idle hold
        for (int i = 0; i < 16; i++)
            drive(1, 1, 8'(16 + i), 32'hC0DE0000 + 32'(i), 4'b1111,
                  1, 1, 8'(32 + i), 32'hBEEF0000 + 32'(i * 7), 4'b1111);
        for (int i = 0; i < 16; i++)
            drive(1, 0, 8'(16 + i), 32'h0, 4'h0, 1, 0, 8'(32 + i), 32'h0, 4'h0);
        idle(4);

        // Reset with two reads in flight
        drive(1, 0, 8'd16, 32'h0, 4'h0, 1, 0, 8'd33, 32'h0, 4'h0);
        drive(1, 0, 8'd17, 32'h0, 4'h0, 1, 0, 8'd34, 32'h0, 4'h0);
        rst = 1'b1;
        en1 = 1'b0;
        en2 = 1'b0;
        #1 check_zero("reset_midop");
        for (int k = 0; k < 4; k++) begin
            sb[k].delete();
            last_d[k] = '0;
            last_k[k] = 1'b1;
        end
        colq.delete();
        idle(2);
        rst = 1'b0;
        idle(4);

        // Contents survive reset
        drive(1, 0, 8'd5, 32'h0, 4'h0, 1, 0, 8'd9, 32'h0, 4'h0);
        idle(4);

        for (int k = 0; k < 4; k++) begin
            n_assert++;
            assert (sb[k].size() == 0) else begin
                n_fail++;
                $error("FAIL drain[%0d] observed=%0d pending expected=0", k, sb[k].size());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
